// File: rtl/amb_islenen_hazirlayici_pkg.sv
// Shared constants for the execute-stage operand front end: ALU op codes,
// operand select encodings and the forward-source encoding.
package amb_islenen_hazirlayici_pkg;

  localparam int VERI_W    = 32;
  localparam int ADRES_W   = 5;
  localparam int KONTROL_W = 4;

  localparam logic [KONTROL_W-1:0] AMB_TOPLA = 4'd0;
  localparam logic [KONTROL_W-1:0] AMB_CIKAR = 4'd1;
  localparam logic [KONTROL_W-1:0] AMB_VE    = 4'd2;
  localparam logic [KONTROL_W-1:0] AMB_VEYA  = 4'd3;
  localparam logic [KONTROL_W-1:0] AMB_XOR   = 4'd4;
  localparam logic [KONTROL_W-1:0] AMB_SLT   = 4'd5;
  localparam logic [KONTROL_W-1:0] AMB_SLTU  = 4'd6;
  localparam logic [KONTROL_W-1:0] AMB_SLL   = 4'd7;
  localparam logic [KONTROL_W-1:0] AMB_SRL   = 4'd8;
  localparam logic [KONTROL_W-1:0] AMB_SRA   = 4'd9;

  localparam logic ISLENEN1_RS1   = 1'b0;
  localparam logic ISLENEN1_PS    = 1'b1;
  localparam logic ISLENEN2_RS2   = 1'b0;
  localparam logic ISLENEN2_ANLIK = 1'b1;

  typedef enum logic [1:0] {
    YON_YURUT   = 2'd0,
    YON_BELLEK  = 2'd1,
    YON_GERIYAZ = 2'd2,
    YON_YAZMAC  = 2'd3
  } yon_kaynak_t;

  // x0 is hardwired zero, so it never takes part in forwarding or hazards.
  function automatic logic adres_eslesir(input logic [ADRES_W-1:0] a,
                                         input logic [ADRES_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/amb_islenen_hazirlayici_yonlendirme_birimi.sv
// One source operand: priority forward mux (execute > memory > writeback >
// register file) and the load-use hazard flag for that source.
module yonlendirme_birimi
  import amb_islenen_hazirlayici_pkg::*;
(
  input  logic                kullan_i,
  input  logic [ADRES_W-1:0]  adres_i,
  input  logic [VERI_W-1:0]   yazmac_deger_i,
  input  logic                yurut_gecerli_i,
  input  logic                yurut_hazir_i,
  input  logic                yurut_yukle_i,
  input  logic [ADRES_W-1:0]  yurut_rd_i,
  input  logic [VERI_W-1:0]   yurut_sonuc_i,
  input  logic                bellek_gecerli_i,
  input  logic                bellek_yukle_i,
  input  logic [ADRES_W-1:0]  bellek_rd_i,
  input  logic [VERI_W-1:0]   bellek_sonuc_i,
  input  logic                geriyaz_gecerli_i,
  input  logic [ADRES_W-1:0]  geriyaz_rd_i,
  input  logic [VERI_W-1:0]   geriyaz_sonuc_i,
  output logic [VERI_W-1:0]   deger_o,
  output logic                durak_o
);

  logic yurut_es, bellek_es, geriyaz_es;
  yon_kaynak_t kaynak;

  assign yurut_es   = adres_eslesir(adres_i, yurut_rd_i);
  assign bellek_es  = adres_eslesir(adres_i, bellek_rd_i);
  assign geriyaz_es = adres_eslesir(adres_i, geriyaz_rd_i);

  always_comb begin
    kaynak = YON_YAZMAC;
    if (yurut_gecerli_i && yurut_hazir_i && !yurut_yukle_i && yurut_es)
      kaynak = YON_YURUT;
    else if (bellek_gecerli_i && !bellek_yukle_i && bellek_es)
      kaynak = YON_BELLEK;
    else if (geriyaz_gecerli_i && geriyaz_es)
      kaynak = YON_GERIYAZ;
  end

  always_comb begin
    deger_o = yazmac_deger_i;
    case (kaynak)
      YON_YURUT:   deger_o = yurut_sonuc_i;
      YON_BELLEK:  deger_o = bellek_sonuc_i;
      YON_GERIYAZ: deger_o = geriyaz_sonuc_i;
      default:     deger_o = yazmac_deger_i;
    endcase
  end

  // Load data is not ready until after the memory stage completes.
  assign durak_o = kullan_i &&
                   ((yurut_gecerli_i && yurut_yukle_i && yurut_es) ||
                    (bellek_gecerli_i && bellek_yukle_i && bellek_es));

endmodule

// File: rtl/amb_islenen_hazirlayici.sv
// Execute-stage front end: accepts decoded micro-ops, forwards and selects
// operands, stalls on load-use hazards and holds one micro-op for the ALU.
module amb_islenen_hazirlayici
  import amb_islenen_hazirlayici_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         gecerli_i,
  output logic         hazir_o,
  input  logic [3:0]   amb_kontrol_i,
  input  logic [4:0]   rs1_adres_i,
  input  logic [4:0]   rs2_adres_i,
  input  logic [4:0]   rd_adres_i,
  input  logic [31:0]  rs1_deger_i,
  input  logic [31:0]  rs2_deger_i,
  input  logic [31:0]  anlik_i,
  input  logic [31:0]  ps_i,
  input  logic         deger1_sec_i,
  input  logic         deger2_sec_i,
  input  logic         yukle_i,
  input  logic [31:0]  yurut_sonuc_i,
  input  logic         bellek_gecerli_i,
  input  logic [4:0]   bellek_rd_i,
  input  logic [31:0]  bellek_sonuc_i,
  input  logic         bellek_yukle_i,
  input  logic         geriyaz_gecerli_i,
  input  logic [4:0]   geriyaz_rd_i,
  input  logic [31:0]  geriyaz_sonuc_i,
  input  logic         temizle_i,
  output logic         amb_gecerli_o,
  input  logic         amb_hazir_i,
  output logic [3:0]   amb_kontrol_o,
  output logic [31:0]  deger1_o,
  output logic [31:0]  deger2_o,
  output logic [1:0]   lt_ltu_o,
  output logic [4:0]   rd_adres_o,
  output logic         yukle_o,
  output logic [31:0]  durak_sayac_o
);

  logic        gecerli_q;
  logic [3:0]  kontrol_q;
  logic [31:0] deger1_q, deger2_q, sayac_q;
  logic [1:0]  lt_q;
  logic [4:0]  rd_q;
  logic        yukle_q;

  logic [31:0] yon1, yon2, deger1_d, deger2_d;
  logic [1:0]  lt_d;
  logic        durak1, durak2, durak, kabul;

  yonlendirme_birimi u_yon1 (
    .kullan_i          (deger1_sec_i == ISLENEN1_RS1),
    .adres_i           (rs1_adres_i),
    .yazmac_deger_i    (rs1_deger_i),
    .yurut_gecerli_i   (gecerli_q),
    .yurut_hazir_i     (amb_hazir_i),
    .yurut_yukle_i     (yukle_q),
    .yurut_rd_i        (rd_q),
    .yurut_sonuc_i     (yurut_sonuc_i),
    .bellek_gecerli_i  (bellek_gecerli_i),
    .bellek_yukle_i    (bellek_yukle_i),
    .bellek_rd_i       (bellek_rd_i),
    .bellek_sonuc_i    (bellek_sonuc_i),
    .geriyaz_gecerli_i (geriyaz_gecerli_i),
    .geriyaz_rd_i      (geriyaz_rd_i),
    .geriyaz_sonuc_i   (geriyaz_sonuc_i),
    .deger_o           (yon1),
    .durak_o           (durak1)
  );

  yonlendirme_birimi u_yon2 (
    .kullan_i          (deger2_sec_i == ISLENEN2_RS2),
    .adres_i           (rs2_adres_i),
    .yazmac_deger_i    (rs2_deger_i),
    .yurut_gecerli_i   (gecerli_q),
    .yurut_hazir_i     (amb_hazir_i),
    .yurut_yukle_i     (yukle_q),
    .yurut_rd_i        (rd_q),
    .yurut_sonuc_i     (yurut_sonuc_i),
    .bellek_gecerli_i  (bellek_gecerli_i),
    .bellek_yukle_i    (bellek_yukle_i),
    .bellek_rd_i       (bellek_rd_i),
    .bellek_sonuc_i    (bellek_sonuc_i),
    .geriyaz_gecerli_i (geriyaz_gecerli_i),
    .geriyaz_rd_i      (geriyaz_rd_i),
    .geriyaz_sonuc_i   (geriyaz_sonuc_i),
    .deger_o           (yon2),
    .durak_o           (durak2)
  );

  assign durak    = gecerli_i && (durak1 || durak2);
  assign hazir_o  = !durak && !temizle_i && (!gecerli_q || amb_hazir_i);
  assign kabul    = gecerli_i && hazir_o;

  assign deger1_d = (deger1_sec_i == ISLENEN1_PS)    ? ps_i    : yon1;
  assign deger2_d = (deger2_sec_i == ISLENEN2_ANLIK) ? anlik_i : yon2;
  // Comparison flags are precomputed here so the ALU sees them registered.
  assign lt_d     = {deger1_d < deger2_d, $signed(deger1_d) < $signed(deger2_d)};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gecerli_q <= 1'b0;
      kontrol_q <= '0;
      deger1_q  <= '0;
      deger2_q  <= '0;
      lt_q      <= '0;
      rd_q      <= '0;
      yukle_q   <= 1'b0;
      sayac_q   <= '0;
    end else begin
      if (temizle_i) begin
        gecerli_q <= 1'b0;
      end else if (kabul) begin
        gecerli_q <= 1'b1;
        kontrol_q <= amb_kontrol_i;
        deger1_q  <= deger1_d;
        deger2_q  <= deger2_d;
        lt_q      <= lt_d;
        rd_q      <= rd_adres_i;
        yukle_q   <= yukle_i;
      end else if (amb_hazir_i) begin
        gecerli_q <= 1'b0;
      end
      if (durak && !temizle_i)
        sayac_q <= sayac_q + 32'd1;
    end
  end

  assign amb_gecerli_o = gecerli_q;
  assign amb_kontrol_o = kontrol_q;
  assign deger1_o      = deger1_q;
  assign deger2_o      = deger2_q;
  assign lt_ltu_o      = lt_q;
  assign rd_adres_o    = rd_q;
  assign yukle_o       = yukle_q;
  assign durak_sayac_o = sayac_q;

endmodule

// File: tb/tb_amb_islenen_hazirlayici.sv
// Directed bench: expected ALU-side micro-ops are queued when driven and
// compared when the registered micro-op appears.
module tb_amb_islenen_hazirlayici;
  import amb_islenen_hazirlayici_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni, gecerli_i, hazir_o;
  logic [3:0]  amb_kontrol_i;
  logic [4:0]  rs1_adres_i, rs2_adres_i, rd_adres_i;
  logic [31:0] rs1_deger_i, rs2_deger_i, anlik_i, ps_i;
  logic        deger1_sec_i, deger2_sec_i, yukle_i;
  logic [31:0] yurut_sonuc_i;
  logic        bellek_gecerli_i, bellek_yukle_i;
  logic [4:0]  bellek_rd_i;
  logic [31:0] bellek_sonuc_i;
  logic        geriyaz_gecerli_i;
  logic [4:0]  geriyaz_rd_i;
  logic [31:0] geriyaz_sonuc_i;
  logic        temizle_i, amb_gecerli_o, amb_hazir_i;
  logic [3:0]  amb_kontrol_o;
  logic [31:0] deger1_o, deger2_o, durak_sayac_o;
  logic [1:0]  lt_ltu_o;
  logic [4:0]  rd_adres_o;
  logic        yukle_o;

  amb_islenen_hazirlayici dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .gecerli_i(gecerli_i), .hazir_o(hazir_o),
    .amb_kontrol_i(amb_kontrol_i), .rs1_adres_i(rs1_adres_i),
    .rs2_adres_i(rs2_adres_i), .rd_adres_i(rd_adres_i),
    .rs1_deger_i(rs1_deger_i), .rs2_deger_i(rs2_deger_i), .anlik_i(anlik_i),
    .ps_i(ps_i), .deger1_sec_i(deger1_sec_i), .deger2_sec_i(deger2_sec_i),
    .yukle_i(yukle_i), .yurut_sonuc_i(yurut_sonuc_i),
    .bellek_gecerli_i(bellek_gecerli_i), .bellek_rd_i(bellek_rd_i),
    .bellek_sonuc_i(bellek_sonuc_i), .bellek_yukle_i(bellek_yukle_i),
    .geriyaz_gecerli_i(geriyaz_gecerli_i), .geriyaz_rd_i(geriyaz_rd_i),
    .geriyaz_sonuc_i(geriyaz_sonuc_i), .temizle_i(temizle_i),
    .amb_gecerli_o(amb_gecerli_o), .amb_hazir_i(amb_hazir_i),
    .amb_kontrol_o(amb_kontrol_o), .deger1_o(deger1_o), .deger2_o(deger2_o),
    .lt_ltu_o(lt_ltu_o), .rd_adres_o(rd_adres_o), .yukle_o(yukle_o),
    .durak_sayac_o(durak_sayac_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  kontrol;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  lt;
    logic [4:0]  rd;
    logic        yukle;
  } beklenen_t;

  beklenen_t sb_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bekle(input logic [3:0] k, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [1:0] lt, input logic [4:0] rd, input logic ld);
    beklenen_t b;
    b.kontrol = k; b.d1 = d1; b.d2 = d2; b.lt = lt; b.rd = rd; b.yukle = ld;
    sb_q.push_back(b);
  endtask

  // With al=1 the entry is consumed; with al=0 it is only peeked (held output).
  task automatic cikis_kontrol(input string tag, input bit al);
    beklenen_t b;
    chk({tag, "_kuyruk"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() == 0) return;
    b = sb_q[0];
    if (al) void'(sb_q.pop_front());
    chk({tag, "_gecerli"}, 32'(amb_gecerli_o), 32'd1);
    chk({tag, "_kontrol"}, 32'(amb_kontrol_o), 32'(b.kontrol));
    chk({tag, "_deger1"},  deger1_o, b.d1);
    chk({tag, "_deger2"},  deger2_o, b.d2);
    chk({tag, "_lt"},      32'(lt_ltu_o), 32'(b.lt));
    chk({tag, "_rd"},      32'(rd_adres_o), 32'(b.rd));
    chk({tag, "_yukle"},   32'(yukle_o), 32'(b.yukle));
  endtask

  task automatic islem(input logic [3:0] k, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic s1, input logic s2, input logic ld);
    gecerli_i = 1'b1; amb_kontrol_i = k;
    rs1_adres_i = r1; rs2_adres_i = r2; rd_adres_i = rd;
    rs1_deger_i = v1; rs2_deger_i = v2; anlik_i = imm; ps_i = pc;
    deger1_sec_i = s1; deger2_sec_i = s2; yukle_i = ld;
  endtask

  task automatic bellek(input logic g, input logic [4:0] rd, input logic [31:0] v, input logic ld);
    bellek_gecerli_i = g; bellek_rd_i = rd; bellek_sonuc_i = v; bellek_yukle_i = ld;
  endtask

  task automatic geriyaz(input logic g, input logic [4:0] rd, input logic [31:0] v);
    geriyaz_gecerli_i = g; geriyaz_rd_i = rd; geriyaz_sonuc_i = v;
  endtask

  task automatic kenar();
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_ni = 1'b0; gecerli_i = 1'b0; temizle_i = 1'b0; amb_hazir_i = 1'b1;
    islem(AMB_TOPLA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    gecerli_i = 1'b0;
    yurut_sonuc_i = '0;
    bellek(0, 0, 0, 0);
    geriyaz(0, 0, 0);
    repeat (2) kenar();
    rst_ni = 1'b1;

    @(negedge clk_i);
    chk("reset_gecerli", 32'(amb_gecerli_o), 32'd0);
    chk("reset_sayac", durak_sayac_o, 32'd0);
    chk("reset_hazir", 32'(hazir_o), 32'd1);

    // Plain ADD x3 = x1 + x2
    islem(AMB_TOPLA, 1, 2, 3, 32'd5, 32'd7, 0, 32'h40, ISLENEN1_RS1, ISLENEN2_RS2, 0);
    bekle(AMB_TOPLA, 32'd5, 32'd7, 2'b11, 5'd3, 1'b0);
    @(negedge clk_i);
    chk("add_hazir", 32'(hazir_o), 32'd1);
    kenar();

    // Dependent op: execute result must beat memory and writeback on x3
    yurut_sonuc_i = 32'h10;
    bellek(1, 3, 32'h20, 0);
    geriyaz(1, 3, 32'h30);
    islem(AMB_CIKAR, 3, 2, 5, 32'h99, 32'd7, 0, 0, ISLENEN1_RS1, ISLENEN2_RS2, 0);
    bekle(AMB_CIKAR, 32'h10, 32'd7, 2'b00, 5'd5, 1'b0);
    @(negedge clk_i);
    cikis_kontrol("add", 1);
    chk("arka_arkaya_hazir", 32'(hazir_o), 32'd1);
    kenar();

    // rs1 from writeback, rs2 from memory
    yurut_sonuc_i = 32'h55;
    bellek(1, 3, 32'h20, 0);
    geriyaz(1, 2, 32'h30);
    islem(AMB_VEYA, 2, 3, 6, 32'd9, 32'h77, 0, 0, ISLENEN1_RS1, ISLENEN2_RS2, 0);
    bekle(AMB_VEYA, 32'h30, 32'h20, 2'b00, 5'd6, 1'b0);
    @(negedge clk_i);
    cikis_kontrol("yurut_oncelik", 1);
    kenar();

    // PC and immediate selected: signed and unsigned compare disagree
    bellek(0, 0, 0, 0);
    geriyaz(0, 0, 0);
    islem(AMB_SLT, 0, 0, 7, 0, 0, 32'd1, 32'h8000_0000, ISLENEN1_PS, ISLENEN2_ANLIK, 0);
    bekle(AMB_SLT, 32'h8000_0000, 32'd1, 2'b01, 5'd7, 1'b0);
    @(negedge clk_i);
    cikis_kontrol("bellek_geriyaz", 1);
    kenar();

    // Load to x4
    islem(AMB_TOPLA, 1, 0, 4, 32'h100, 0, 32'd8, 0, ISLENEN1_RS1, ISLENEN2_ANLIK, 1);
    bekle(AMB_TOPLA, 32'h100, 32'd8, 2'b00, 5'd4, 1'b1);
    @(negedge clk_i);
    cikis_kontrol("ps_anlik", 1);
    kenar();

    // Load-use on x4: one stall cycle, then memory forward
    islem(AMB_TOPLA, 4, 2, 6, 32'd0, 32'd7, 0, 0, ISLENEN1_RS1, ISLENEN2_RS2, 0);
    @(negedge clk_i);
    cikis_kontrol("yukleme", 1);
    chk("yukleme_kullanim_hazir", 32'(hazir_o), 32'd0);
    kenar();
    bellek(1, 4, 32'hAB, 0);
    bekle(AMB_TOPLA, 32'hAB, 32'd7, 2'b00, 5'd6, 1'b0);
    @(negedge clk_i);
    chk("durak_sayac_1", durak_sayac_o, 32'd1);
    chk("durak_gecerli", 32'(amb_gecerli_o), 32'd0);
    chk("durak_sonrasi_hazir", 32'(hazir_o), 32'd1);
    kenar();

    // Load still in memory stage on x4: stalls only while rs2 is actually used
    bellek(1, 4, 32'h5, 1);
    islem(AMB_VE, 1, 4, 8, 32'd3, 0, 32'd3, 0, ISLENEN1_RS1, ISLENEN2_RS2, 0);
    @(negedge clk_i);
    cikis_kontrol("bellek_ileri", 1);
    chk("bellek_yukle_hazir", 32'(hazir_o), 32'd0);
    deger2_sec_i = ISLENEN2_ANLIK;
    #1;
    chk("kullanilmayan_rs2_hazir", 32'(hazir_o), 32'd1);
    bekle(AMB_VE, 32'd3, 32'd3, 2'b00, 5'd8, 1'b0);
    kenar();

    // x0 never forwards
    bellek(1, 0, 32'hFF, 0);
    geriyaz(1, 0, 32'hEE);
    islem(AMB_TOPLA, 0, 2, 9, 32'd0, 32'd1, 0, 0, ISLENEN1_RS1, ISLENEN2_RS2, 0);
    bekle(AMB_TOPLA, 32'd0, 32'd1, 2'b11, 5'd9, 1'b0);
    @(negedge clk_i);
    cikis_kontrol("kaynak_secimi", 1);
    chk("durak_sayac_sabit", durak_sayac_o, 32'd1);
    kenar();

    // Backpressure for three cycles, then flush
    bellek(0, 0, 0, 0);
    geriyaz(0, 0, 0);
    amb_hazir_i = 1'b0;
    islem(AMB_CIKAR, 1, 2, 10, 32'd1, 32'd2, 0, 0, ISLENEN1_RS1, ISLENEN2_RS2, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      cikis_kontrol("geri_basinc", 0);
      chk("geri_basinc_hazir", 32'(hazir_o), 32'd0);
      kenar();
    end
    temizle_i = 1'b1;
    @(negedge clk_i);
    chk("temizle_hazir", 32'(hazir_o), 32'd0);
    kenar();
    temizle_i = 1'b0; gecerli_i = 1'b0; amb_hazir_i = 1'b1;
    @(negedge clk_i);
    chk("temizle_gecerli", 32'(amb_gecerli_o), 32'd0);
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    chk("kuyruk_bos", 32'(sb_q.size()), 32'd0);
    kenar();

    // Reset in the middle of a load-use stall
    islem(AMB_VE, 1, 0, 4, 32'h100, 0, 32'd8, 0, ISLENEN1_RS1, ISLENEN2_ANLIK, 1);
    kenar();
    amb_hazir_i = 1'b0;
    islem(AMB_TOPLA, 4, 2, 6, 0, 32'd7, 0, 0, ISLENEN1_RS1, ISLENEN2_RS2, 0);
    repeat (2) kenar();
    @(negedge clk_i);
    chk("sifir_oncesi_sayac", durak_sayac_o, 32'd3);
    chk("sifir_oncesi_yukle", 32'(yukle_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("sifir_gecerli", 32'(amb_gecerli_o), 32'd0);
    chk("sifir_kontrol", 32'(amb_kontrol_o), 32'd0);
    chk("sifir_deger1", deger1_o, 32'd0);
    chk("sifir_deger2", deger2_o, 32'd0);
    chk("sifir_lt", 32'(lt_ltu_o), 32'd0);
    chk("sifir_rd", 32'(rd_adres_o), 32'd0);
    chk("sifir_yukle", 32'(yukle_o), 32'd0);
    chk("sifir_sayac", durak_sayac_o, 32'd0);
    gecerli_i = 1'b0;
    kenar();
    rst_ni = 1'b1;
    kenar();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
